// File: rtl/data_mem_pkg.sv
// Shared definitions for the CPU data memory: controller state encoding and
// the default geometry used by both this block and the CPU top.
package data_mem_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 256;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/data_mem_ctrl_mem_array.sv
// Raw DEPTH x DATA_W storage: one synchronous write port and one
// combinational read port. Range checking is the controller's job.
module mem_array #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Synchronous write port.
  // NOTE: the array has no reset; it must map onto plain RAM, and the
  // controller's clear sweep zeroes it after reset instead.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller for the 4-bit CPU: valid/ready handshake,
// registered read data, out-of-range flagging and a hardware clear sweep
// that runs after reset and on request.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err
);

  // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rvalid;
  logic                r_err;

  logic                w_accept;
  logic                w_in_range;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_waddr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic [DATA_W-1:0]   w_mem_rdata;

  assign ready      = (r_state == ST_IDLE);
  assign busy       = (r_state == ST_CLEAR);
  assign w_accept   = req && ready;
  assign w_in_range = ({1'b0, addr} < DEPTH_W);

  // State and sweep-counter register; reset restarts the sweep at location 0.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, sweep counter and write-port mux (sweep owns the port in CLEAR).
  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mem_we    = 1'b0;
    w_mem_waddr = addr;
    w_mem_wdata = wdata;
    unique case (r_state)
      ST_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_waddr = r_cnt;
        w_mem_wdata = '0;
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        w_mem_we = w_accept && we && w_in_range;
        if (clr) begin
          w_state_nxt = ST_CLEAR;
        end
      end
    endcase
  end

  // Read result and status pulses; rdata holds until the next accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_accept && !we;
      r_err    <= w_accept && !w_in_range;
      if (w_accept && !we) begin
        r_rdata <= w_in_range ? w_mem_rdata : '0;
      end
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign err    = r_err;

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (w_mem_wdata),
    .i_raddr (addr),
    .o_rdata (w_mem_rdata)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a default 256-deep instance and a
// 200-deep instance for out-of-range behaviour, sharing clock and reset.
module tb_data_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;

  // default instance
  logic       clr, req, we;
  logic [7:0] addr;
  logic [3:0] wdata;
  logic       ready, busy, rvalid, err;
  logic [3:0] rdata;

  // DEPTH = 200 instance
  logic       clr_b, req_b, we_b;
  logic [7:0] addr_b;
  logic [3:0] wdata_b;
  logic       ready_b, busy_b, rvalid_b, err_b;
  logic [3:0] rdata_b;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  data_mem_ctrl u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .ready  (ready),
    .busy   (busy),
    .rdata  (rdata),
    .rvalid (rvalid),
    .err    (err)
  );

  data_mem_ctrl #(.DATA_W(4), .ADDR_W(8), .DEPTH(200)) u_dut200 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr_b),
    .req    (req_b),
    .we     (we_b),
    .addr   (addr_b),
    .wdata  (wdata_b),
    .ready  (ready_b),
    .busy   (busy_b),
    .rdata  (rdata_b),
    .rvalid (rvalid_b),
    .err    (err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    clr_b = 1'b0; req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   busy,   1);
    check({tag, "_ready"},  ready,  0);
    check({tag, "_rdata"},  rdata,  0);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_err"},    err,    0);
    check({tag, "_busy_b"}, busy_b, 1);
    check({tag, "_rdata_b"}, rdata_b, 0);
  endtask

  // Count edges until ready rises on each instance (bounded).
  task automatic sweep_len(output int n_a, output int n_b);
    n_a = -1;
    n_b = -1;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (ready_b && n_b < 0) n_b = k;
      if (ready && n_a < 0) n_a = k;
      if (n_a >= 0 && n_b >= 0) break;
    end
  endtask

  // Single accepted access on the default instance.
  task automatic access(input logic w, input logic [7:0] a, input logic [3:0] d);
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic access_b(input logic w, input logic [7:0] a, input logic [3:0] d);
    req_b = 1'b1; we_b = w; addr_b = a; wdata_b = d;
    tick();
    req_b = 1'b0; we_b = 1'b0;
  endtask

  logic [3:0] model [256];

  initial begin
    int n_a, n_b, busy_cnt;
    idle_inputs();

    // Reset state
    rst_n = 1'b0;
    #12;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Power-up sweep: exactly DEPTH edges on each instance
    sweep_len(n_a, n_b);
    check("sweep256_len", n_a, 256);
    check("sweep200_len", n_b, 200);
    check("sweep_busy_low", busy, 0);

    // Read after sweep returns zero, rvalid pulses once
    access(1'b0, 8'h7F, 4'h0);
    check("rd7f_rvalid", rvalid, 1);
    check("rd7f_rdata", rdata, 0);
    check("rd7f_err", err, 0);
    tick();
    check("rd7f_rvalid_fall", rvalid, 0);

    // Write 0xA to 0x10, read it next cycle
    access(1'b1, 8'h10, 4'hA);
    check("wr10_rvalid", rvalid, 0);
    access(1'b0, 8'h10, 4'h0);
    check("rd10_rvalid", rvalid, 1);
    check("rd10_rdata", rdata, 4'hA);

    // Back-to-back stream: write i, read i, one accepted access per cycle
    foreach (model[i]) model[i] = 4'h0;
    model[8'h10] = 4'hA;
    for (int i = 0; i < 256; i++) begin
      model[i] = 4'((i * 7 + 3) & 15);
      req = 1'b1; we = 1'b1; addr = 8'(i); wdata = model[i];
      tick();
      check("stream_ready", ready, 1);
      we = 1'b0;
      tick();
      if (!rvalid || rdata !== model[i]) begin
        check($sformatf("stream_rd_%0h", i), {rvalid, rdata}, {1'b1, model[i]});
      end else begin
        n_total++;
      end
    end
    req = 1'b0;
    tick();
    check("stream_rvalid_fall", rvalid, 0);
    // readback of a few addresses after the stream
    access(1'b0, 8'h00, 4'h0);
    check("readback_00", rdata, model[0]);
    access(1'b0, 8'hFF, 4'h0);
    check("readback_ff", rdata, model[255]);
    access(1'b0, 8'h81, 4'h0);
    check("readback_81", rdata, model[8'h81]);

    // DEPTH = 200: out-of-range write/read, last valid location intact
    access_b(1'b1, 8'hC7, 4'h9);
    check("b_wrc7_err", err_b, 0);
    access_b(1'b1, 8'hC8, 4'h5);
    check("b_wrc8_err", err_b, 1);
    check("b_wrc8_rvalid", rvalid_b, 0);
    access_b(1'b0, 8'hC8, 4'h0);
    check("b_rdc8_err", err_b, 1);
    check("b_rdc8_rvalid", rvalid_b, 1);
    check("b_rdc8_rdata", rdata_b, 0);
    access_b(1'b0, 8'hC7, 4'h0);
    check("b_rdc7_err", err_b, 0);
    check("b_rdc7_rdata", rdata_b, 4'h9);
    tick();
    check("b_err_fall", err_b, 0);
    check("b_rdata_hold", rdata_b, 4'h9);

    // Write then clr together with a read: read completes, sweep follows
    access(1'b1, 8'h20, 4'h3);
    clr = 1'b1;
    access(1'b0, 8'h20, 4'h0);
    check("clr_rd20_rvalid", rvalid, 1);
    check("clr_rd20_rdata", rdata, 4'h3);
    check("clr_busy", busy, 1);
    // clr held and req presented during the sweep: both ignored
    busy_cnt = 1;
    req = 1'b1; we = 1'b0; addr = 8'h20;
    for (int k = 0; k < 10; k++) begin
      tick();
      busy_cnt++;
    end
    check("sweep_req_ignored", rvalid, 0);
    check("sweep_rdata_hold", rdata, 4'h3);
    clr = 1'b0; req = 1'b0;
    while (busy && busy_cnt < 600) begin
      tick();
      if (busy) busy_cnt++;
    end
    check("clr_sweep_len", busy_cnt, 256);
    check("clr_ready", ready, 1);
    access(1'b0, 8'h20, 4'h0);
    check("clr_rd20_zero", rdata, 0);
    access(1'b0, 8'h10, 4'h0);
    check("clr_rd10_zero", rdata, 0);

    // Reset asserted at sweep cycle 100
    access(1'b1, 8'h30, 4'h6);
    clr = 1'b1;
    access(1'b0, 8'h30, 4'h0);
    clr = 1'b0;
    check("pre_rst_rdata", rdata, 4'h6);
    for (int k = 0; k < 99; k++) tick();
    check("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    check("midrst_hold_busy", busy, 1);
    rst_n = 1'b1;
    sweep_len(n_a, n_b);
    check("resweep256_len", n_a, 256);
    check("resweep200_len", n_b, 200);
    access(1'b0, 8'h30, 4'h0);
    check("resweep_rd30", rdata, 0);
    check("resweep_rvalid", rvalid, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
